ddr2_traffic_gen: RTL and testbench
===================================

# ddr2_traffic_gen

Synthesizable traffic generator and checker that drives the DDR2 controller's client port (`c_addr`/`c_data_in`/`c_rd_req`/`c_wr_req`/`c_ack`/`c_rdy`/`c_data_out`). It replaces hand-sequenced bench stimulus with a parametrised engine. It writes a deterministic pattern over an address window, reads the window back, and compares each word. Errors are counted, the first failure is logged, and a hung handshake is reported through a timeout. It sits between a bench or on-chip BIST controller and `controller`.

## Interface
Parameters:
- `ADDR_W`, 26: client address width.
- `DATA_W`, 64: client data width; must be a multiple of 32.
- `NUM_WORDS`, 16: words per pass; at least 1.
- `BASE_ADDR`, 0: first address.
- `ADDR_STRIDE`, 1: address increment per word; sums wrap modulo 2^ADDR_W.
- `PATTERN`, 0: 0 = index pattern, 1 = LFSR pattern.
- `SEED`, 32'hACE1_0001: LFSR seed; must be nonzero.
- `TIMEOUT`, 4096: maximum cycles spent waiting in any one state.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: synchronous active-low reset.
- `start` in 1: one-cycle pulse that begins a run; ignored while `busy`.
- `mode` in 2: 0 = write only, 1 = read/verify only, 2 = write then verify, 3 = reserved (behaves as 2). Sampled on `start`.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run ends.
- `pass` out 1: valid from `done` until the next `start`; 1 = zero errors and no timeout.
- `timeout` out 1: sticky until the next `start`.
- `err_count` out 16: number of mismatched words; saturates at 16'hFFFF.
- `first_err_addr` out ADDR_W: address of the first mismatch.
- `first_err_data` out DATA_W: data read at the first mismatch.
- `c_addr` out ADDR_W, `c_data_in` out DATA_W, `c_rd_req` out 1, `c_wr_req` out 1: requests to the controller.
- `c_ack` in 1, `c_rdy` in 1, `c_data_out` in DATA_W: responses from the controller.

## Operation
- States are IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FAULT, FIN.
- **IDLE:** on `start`, set `busy`, clear the statistics, and load index 0, address `BASE_ADDR` and the LFSR from `SEED`. Go to WR_REQ (modes 0, 2, 3) or RD_REQ (mode 1).
- **WR_REQ / RD_REQ:** assert the request only once `c_rdy`=1 is sampled. Hold the request, `c_addr` and `c_data_in` stable until `c_ack`=1 is sampled. In that cycle, drop the request and go to the matching WAIT state.
- **WR_WAIT / RD_WAIT:** wait for `c_rdy`=1. In RD_WAIT, that cycle captures `c_data_out` and compares it with the expected word. Then advance the index, address and LFSR.
  - If the index was `NUM_WORDS-1`: WR_WAIT goes to RD_REQ (mode 2/3) or FIN (mode 0); RD_WAIT goes to FIN.
  - Otherwise, return to the same REQ state.
- **Pattern 0:** word i is the 32-bit value {i[15:0], ~i[15:0]} replicated to DATA_W.
- **Pattern 1:** word i is a 32-bit Galois LFSR (taps 32,22,2,1) after i steps from `SEED`, replicated. The read phase restarts the LFSR from `SEED`.
- **Mismatch:** increment `err_count` (saturating). On the first mismatch only, latch `first_err_addr` and `first_err_data`.
- **Timeout:** the wait counter clears on every state change. If it reaches `TIMEOUT`, go to FAULT: drop both requests and set `timeout`=1. FAULT goes to FIN on the next cycle.
- **FIN:** pulse `done` and set `pass` = (`err_count`==0 && !`timeout`). Clear `busy` and return to IDLE.
- `c_rd_req` and `c_wr_req` are never asserted together.

## Timing
- **Reset values** (`rst_n`=0 at a clock edge): state IDLE; `busy`, `done`, `pass`, `timeout`, `c_rd_req`, `c_wr_req` = 0; `err_count`, `first_err_addr`, `first_err_data`, `c_addr`, `c_data_in` = 0.
- Reset during a run aborts immediately with no `done` pulse. Outstanding requests drop in the same edge.
- `start` to first request: 1 cycle if `c_rdy`=1 (register on `start`, request visible the next cycle).
- Minimum cost per word is 2 cycles (REQ with immediate `c_ack`, WAIT with immediate `c_rdy`).
- `done` is asserted exactly 1 cycle after the final RD_WAIT/WR_WAIT completion, or 2 cycles after the timeout hit (via FAULT).
- `start` arriving in the same cycle as `done` is ignored; a new run needs `start` in a later cycle.
- `c_ack` seen while no request is asserted is ignored.
- Address wrap: `BASE_ADDR + i*ADDR_STRIDE` truncates to ADDR_W with no flag.

## Structure
- Shared package `ddr2_tg_pkg`: the state encoding enum, the mode encoding constants, and the LFSR tap constant.
- One sub-module, `tg_lfsr32`: inputs load, seed and step; output the current value. It is instantiated once and reloaded at each phase start.
- Everything else is flat in `ddr2_traffic_gen`.

## Test plan
- **Clean run:** `NUM_WORDS`=4, `BASE_ADDR`=0x100, `ADDR_STRIDE`=8, `PATTERN`=0, mode 2, against a behavioural memory that acks after 3 cycles. Required: writes to 0x100, 0x108, 0x110, 0x118 with word 1 = 64'h0001FFFE_0001FFFE; reads to the same addresses; `pass`=1, `err_count`=0.
- **Injected error:** as above, but the memory flips bit 0 on the read of 0x110. Required: `err_count`=1, `first_err_addr`=0x110, `first_err_data`=64'h0002FFFD_0002FFFC, `pass`=0.
- **LFSR pattern:** `PATTERN`=1, `SEED`=1, mode 2, 8 words against the real `ddr2` model behind `controller`. Required: `pass`=1; the write and read data sequences are identical.
- **Timeout:** `TIMEOUT`=16, `c_ack` tied to 0. Required: `c_wr_req` high for 16 cycles then drops; `timeout`=1; `done` pulse; `pass`=0; `busy`=0.
- **Reset and re-arm:** `rst_n` low during RD_WAIT of word 2. Required: all outputs at reset values next cycle and no `done`. A `start` asserted during `busy` in a later run changes nothing.
- **Address wrap:** `ADDR_W`=26, `BASE_ADDR`=26'h3FFFFFE, `ADDR_STRIDE`=1, `NUM_WORDS`=4, mode 0. Required: addresses 3FFFFFE, 3FFFFFF, 0000000, 0000001; `done` with `pass`=1.

Source files
------------

// File: rtl/ddr2_tg_pkg.sv
// Shared definitions for the DDR2 traffic generator: FSM states, run modes,
// and the 32-bit Galois LFSR used for the pseudo-random data pattern.
package ddr2_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_FAULT,
        ST_FIN
    } tg_state_t;

    localparam logic [1:0] MODE_WR    = 2'd0;
    localparam logic [1:0] MODE_RD    = 2'd1;
    localparam logic [1:0] MODE_WR_RD = 2'd2;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [31:0] pattern_word(input logic use_lfsr,
                                                 input logic [15:0] idx,
                                                 input logic [31:0] lfsr);
        return use_lfsr ? lfsr : {idx, ~idx};
    endfunction

endpackage

// File: rtl/tg_lfsr32.sv
// 32-bit Galois LFSR with synchronous load; load wins over step so a phase
// restart always begins from the seed.
module tg_lfsr32
    import ddr2_tg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/ddr2_traffic_gen.sv
// Write/read-back traffic generator for the DDR2 controller client port:
// writes a deterministic pattern over an address window, verifies it, and reports.
module ddr2_traffic_gen
    import ddr2_tg_pkg::*;
#(
    parameter int                ADDR_W      = 26,
    parameter int                DATA_W      = 64,
    parameter int                NUM_WORDS   = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       ADDR_STRIDE = 1,
    parameter int                PATTERN     = 0,
    parameter logic [31:0]       SEED        = 32'hACE1_0001,
    parameter int                TIMEOUT     = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data_in,
    output logic              c_rd_req,
    output logic              c_wr_req,
    input  logic              c_ack,
    input  logic              c_rdy,
    input  logic [DATA_W-1:0] c_data_out
);

    localparam int   CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic USE_LFSR = (PATTERN == 1);

    tg_state_t         state;
    logic [1:0]        mode_r;
    logic [31:0]       index;
    logic [CNT_W-1:0]  wait_cnt;

    logic [31:0]       lfsr_value;
    logic [31:0]       lfsr_after;
    logic [15:0]       idx_next;
    logic [31:0]       cur_word32;
    logic [31:0]       next_word32;
    logic [DATA_W-1:0] cur_word;
    logic [DATA_W-1:0] next_word;
    logic              last_word;
    logic              start_ok;
    logic              waiting;
    logic              progress;
    logic              expired;
    logic              lfsr_load;
    logic              lfsr_step;

    tg_lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .seed  (SEED),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    // next_word lets a WAIT state re-issue the following request in the same
    // edge it completes, giving the 2-cycle-per-word best case.
    always_comb begin
        idx_next    = index[15:0] + 16'd1;
        lfsr_after  = lfsr_next(lfsr_value);
        cur_word32  = pattern_word(USE_LFSR, index[15:0], lfsr_value);
        next_word32 = pattern_word(USE_LFSR, idx_next, lfsr_after);
        cur_word    = {(DATA_W/32){cur_word32}};
        next_word   = {(DATA_W/32){next_word32}};
        last_word   = (index == 32'(NUM_WORDS - 1));
        start_ok    = (state == ST_IDLE) && start && !done;
        waiting     = (state == ST_WR_REQ) || (state == ST_WR_WAIT) ||
                      (state == ST_RD_REQ) || (state == ST_RD_WAIT);
        progress    = 1'b0;
        case (state)
            ST_WR_REQ:  progress = c_wr_req && c_ack;
            ST_RD_REQ:  progress = c_rd_req && c_ack;
            ST_WR_WAIT: progress = c_rdy;
            ST_RD_WAIT: progress = c_rdy;
            default:    progress = 1'b0;
        endcase
        expired   = waiting && !progress && (wait_cnt == CNT_W'(TIMEOUT));
        lfsr_load = start_ok ||
                    ((state == ST_WR_WAIT) && c_rdy && last_word && (mode_r != MODE_WR));
        lfsr_step = ((state == ST_WR_WAIT) || (state == ST_RD_WAIT)) && c_rdy && !last_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mode_r         <= MODE_WR;
            index          <= '0;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            c_addr         <= '0;
            c_data_in      <= '0;
            c_rd_req       <= 1'b0;
            c_wr_req       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (expired) begin
                state    <= ST_FAULT;
                c_wr_req <= 1'b0;
                c_rd_req <= 1'b0;
                timeout  <= 1'b1;
                wait_cnt <= '0;
            end else begin
                if (progress) begin
                    wait_cnt <= '0;
                end else if (waiting) begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
                case (state)
                    ST_IDLE: begin
                        if (start_ok) begin
                            busy           <= 1'b1;
                            pass           <= 1'b0;
                            timeout        <= 1'b0;
                            err_count      <= '0;
                            first_err_addr <= '0;
                            first_err_data <= '0;
                            index          <= '0;
                            c_addr         <= BASE_ADDR;
                            mode_r         <= mode;
                            wait_cnt       <= '0;
                            case (mode)
                                MODE_RD:            state <= ST_RD_REQ;
                                MODE_WR, MODE_WR_RD: state <= ST_WR_REQ;
                                default:            state <= ST_WR_REQ;
                            endcase
                        end
                    end
                    ST_WR_REQ: begin
                        if (c_wr_req) begin
                            if (c_ack) begin
                                c_wr_req <= 1'b0;
                                state    <= ST_WR_WAIT;
                            end
                        end else if (c_rdy) begin
                            c_wr_req  <= 1'b1;
                            c_data_in <= cur_word;
                        end
                    end
                    ST_RD_REQ: begin
                        if (c_rd_req) begin
                            if (c_ack) begin
                                c_rd_req <= 1'b0;
                                state    <= ST_RD_WAIT;
                            end
                        end else if (c_rdy) begin
                            c_rd_req <= 1'b1;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (c_rdy) begin
                            if (!last_word) begin
                                index     <= index + 32'd1;
                                c_addr    <= c_addr + ADDR_W'(ADDR_STRIDE);
                                c_wr_req  <= 1'b1;
                                c_data_in <= next_word;
                                state     <= ST_WR_REQ;
                            end else if (mode_r == MODE_WR) begin
                                state <= ST_FIN;
                            end else begin
                                index  <= '0;
                                c_addr <= BASE_ADDR;
                                state  <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_RD_WAIT: begin
                        if (c_rdy) begin
                            if (c_data_out != cur_word) begin
                                if (err_count != 16'hFFFF) begin
                                    err_count <= err_count + 16'd1;
                                end
                                if (err_count == 16'd0) begin
                                    first_err_addr <= c_addr;
                                    first_err_data <= c_data_out;
                                end
                            end
                            if (last_word) begin
                                state <= ST_FIN;
                            end else begin
                                index    <= index + 32'd1;
                                c_addr   <= c_addr + ADDR_W'(ADDR_STRIDE);
                                c_rd_req <= 1'b1;
                                state    <= ST_RD_REQ;
                            end
                        end
                    end
                    ST_FAULT: begin
                        state <= ST_FIN;
                    end
                    ST_FIN: begin
                        done  <= 1'b1;
                        pass  <= (err_count == 16'd0) && !timeout;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr2_traffic_gen.sv
// Directed bench: a 3-cycle-ack memory behind the index-pattern generator and an
// immediate-ack memory behind an LFSR generator whose window wraps the address space.
module tb_ddr2_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start, start_b;
    logic [1:0]  mode, mode_b;

    logic        busy, done, pass, tg_timeout;
    logic [15:0] err_count;
    logic [25:0] first_err_addr, c_addr;
    logic [63:0] first_err_data, c_data_in, c_data_out;
    logic        c_rd_req, c_wr_req, c_ack, c_rdy;

    logic        busy_b, done_b, pass_b, tg_timeout_b;
    logic [15:0] err_count_b;
    logic [25:0] first_err_addr_b, c_addr_b;
    logic [63:0] first_err_data_b, c_data_in_b, c_data_out_b;
    logic        c_rd_req_b, c_wr_req_b, c_ack_b, c_rdy_b;

    int          checks = 0;
    int          failures = 0;

    logic        ack_enable;
    logic        flip_en;
    int          lat_cnt;
    logic [63:0] mem_a [logic [25:0]];
    logic [63:0] mem_b [logic [25:0]];
    logic [25:0] wr_addr_q[$], rd_addr_q[$], wr_addr_b_q[$];
    logic [63:0] wr_data_q[$], wr_data_b_q[$], rd_data_b_q[$];

    always #5 clk = ~clk;

    ddr2_traffic_gen #(
        .ADDR_W(26), .DATA_W(64), .NUM_WORDS(4), .BASE_ADDR(26'h100),
        .ADDR_STRIDE(8), .PATTERN(0), .SEED(32'hACE1_0001), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .busy(busy), .done(done), .pass(pass), .timeout(tg_timeout),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data), .c_addr(c_addr), .c_data_in(c_data_in),
        .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_ack(c_ack), .c_rdy(c_rdy),
        .c_data_out(c_data_out)
    );

    ddr2_traffic_gen #(
        .ADDR_W(26), .DATA_W(64), .NUM_WORDS(4), .BASE_ADDR(26'h3FFFFFE),
        .ADDR_STRIDE(1), .PATTERN(1), .SEED(32'h0000_0001), .TIMEOUT(4096)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .timeout(tg_timeout_b),
        .err_count(err_count_b), .first_err_addr(first_err_addr_b),
        .first_err_data(first_err_data_b), .c_addr(c_addr_b), .c_data_in(c_data_in_b),
        .c_rd_req(c_rd_req_b), .c_wr_req(c_wr_req_b), .c_ack(c_ack_b), .c_rdy(c_rdy_b),
        .c_data_out(c_data_out_b)
    );

    // Memory A acks on the third cycle a request is held; bit 0 of the word at
    // 0x110 can be flipped on read to provoke a mismatch.
    always @(posedge clk) begin
        if (!rst_n) begin
            c_ack   <= 1'b0;
            lat_cnt <= 0;
        end else begin
            c_ack <= 1'b0;
            if ((c_wr_req || c_rd_req) && !c_ack && ack_enable) begin
                if (lat_cnt == 2) begin
                    c_ack   <= 1'b1;
                    lat_cnt <= 0;
                    if (c_wr_req) begin
                        mem_a[c_addr] = c_data_in;
                        wr_addr_q.push_back(c_addr);
                        wr_data_q.push_back(c_data_in);
                    end else begin
                        c_data_out <= mem_a[c_addr] ^
                                      ((flip_en && c_addr == 26'h110) ? 64'd1 : 64'd0);
                        rd_addr_q.push_back(c_addr);
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end else begin
                lat_cnt <= 0;
            end
        end
    end

    assign c_ack_b = c_wr_req_b | c_rd_req_b;
    assign c_rdy_b = 1'b1;

    always @(posedge clk) begin
        if (rst_n) begin
            if (c_wr_req_b) begin
                mem_b[c_addr_b] = c_data_in_b;
                wr_addr_b_q.push_back(c_addr_b);
                wr_data_b_q.push_back(c_data_in_b);
            end
            if (c_rd_req_b) begin
                c_data_out_b <= mem_b[c_addr_b];
                rd_data_b_q.push_back(mem_b[c_addr_b]);
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); rd_addr_q.delete(); wr_data_q.delete();
        wr_addr_b_q.delete(); wr_data_b_q.delete(); rd_data_b_q.delete();
    endtask

    // Pulses start on the chosen generator and returns at the negedge where done shows.
    task automatic apply_stimulus(input bit use_b, input logic [1:0] m, input int max_cycles);
        bit got_done;
        @(negedge clk);
        if (use_b) begin start_b = 1'b1; mode_b = m; end
        else begin start = 1'b1; mode = m; end
        @(negedge clk);
        start = 1'b0; start_b = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < max_cycles && !got_done; i++) begin
            @(negedge clk);
            if (use_b ? done_b : done) got_done = 1'b1;
        end
        check_output("done_seen", 64'(got_done), 64'd1);
    endtask

    logic [63:0] lfsr_words [4];
    logic [25:0] wrap_addrs [4];

    initial begin
        int          cnt;
        bit          got;
        lfsr_words[0] = 64'h00000001_00000001;
        lfsr_words[1] = 64'h80200003_80200003;
        lfsr_words[2] = 64'hC0300002_C0300002;
        lfsr_words[3] = 64'h60180001_60180001;
        wrap_addrs[0] = 26'h3FFFFFE; wrap_addrs[1] = 26'h3FFFFFF;
        wrap_addrs[2] = 26'h0000000; wrap_addrs[3] = 26'h0000001;

        rst_n = 1'b0; start = 1'b0; start_b = 1'b0; mode = 2'd0; mode_b = 2'd0;
        c_rdy = 1'b1; ack_enable = 1'b1; flip_en = 1'b0; c_data_out = '0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_pass", 64'(pass), 64'd0);
        check_output("rst_timeout", 64'(tg_timeout), 64'd0);
        check_output("rst_reqs", 64'({c_wr_req, c_rd_req}), 64'd0);
        check_output("rst_err_count", 64'(err_count), 64'd0);
        check_output("rst_c_addr", 64'(c_addr), 64'd0);
        check_output("rst_c_data_in", c_data_in, 64'd0);
        check_output("rst_first_err", 64'(first_err_addr) | first_err_data, 64'd0);
        rst_n = 1'b1;

        $display("[TB] clean write/verify run");
        clear_logs();
        apply_stimulus(1'b0, 2'd2, 200);
        check_output("clean_pass", 64'(pass), 64'd1);
        check_output("clean_err_count", 64'(err_count), 64'd0);
        check_output("clean_busy", 64'(busy), 64'd0);
        check_output("clean_wr_count", 64'(wr_addr_q.size()), 64'd4);
        check_output("clean_rd_count", 64'(rd_addr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("clean_wr_addr%0d", i), 64'(wr_addr_q[i]), 64'h100 + 64'(8 * i));
            check_output($sformatf("clean_rd_addr%0d", i), 64'(rd_addr_q[i]), 64'h100 + 64'(8 * i));
        end
        check_output("clean_wr_data1", wr_data_q[1], 64'h0001FFFE_0001FFFE);
        check_output("clean_wr_data3", wr_data_q[3], 64'h0003FFFC_0003FFFC);

        $display("[TB] injected read error");
        flip_en = 1'b1;
        apply_stimulus(1'b0, 2'd2, 200);
        flip_en = 1'b0;
        check_output("inj_err_count", 64'(err_count), 64'd1);
        check_output("inj_first_addr", 64'(first_err_addr), 64'h110);
        check_output("inj_first_data", first_err_data, 64'h0002FFFD_0002FFFC);
        check_output("inj_pass", 64'(pass), 64'd0);

        $display("[TB] handshake timeout");
        ack_enable = 1'b0;
        @(negedge clk);
        start = 1'b1; mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        check_output("tmo_busy_first", 64'(busy), 64'd1);
        cnt = 0; got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (c_wr_req) cnt++;
            if (done) got = 1'b1;
        end
        check_output("tmo_done_seen", 64'(got), 64'd1);
        check_output("tmo_req_cycles", 64'(cnt), 64'd16);
        check_output("tmo_flag", 64'(tg_timeout), 64'd1);
        check_output("tmo_pass", 64'(pass), 64'd0);
        check_output("tmo_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check_output("tmo_done_pulse", 64'(done), 64'd0);
        ack_enable = 1'b1;

        $display("[TB] reset during read of word 2");
        clear_logs();
        @(negedge clk);
        start = 1'b1; mode = 2'd1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (c_ack && rd_addr_q.size() == 3) got = 1'b1;
        end
        check_output("rst_run_reached_word2", 64'(got), 64'd1);
        c_rdy = 1'b0;
        @(negedge clk);
        check_output("rst_run_addr_word2", 64'(c_addr), 64'h110);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("abort_busy", 64'(busy), 64'd0);
        check_output("abort_done", 64'(done), 64'd0);
        check_output("abort_reqs", 64'({c_wr_req, c_rd_req}), 64'd0);
        check_output("abort_c_addr", 64'(c_addr), 64'd0);
        rst_n = 1'b1; c_rdy = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) cnt++;
        end
        check_output("abort_quiet", 64'(cnt), 64'd0);

        $display("[TB] start while busy, start alongside done");
        clear_logs();
        @(negedge clk);
        start = 1'b1; mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; mode = 2'd1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check_output("rearm_done_seen", 64'(got), 64'd1);
        check_output("rearm_wr_count", 64'(wr_addr_q.size()), 64'd4);
        check_output("rearm_rd_count", 64'(rd_addr_q.size()), 64'd0);
        check_output("rearm_pass", 64'(pass), 64'd1);
        check_output("rearm_timeout_cleared", 64'(tg_timeout), 64'd0);
        start = 1'b1; mode = 2'd0;
        @(negedge clk);
        start = 1'b0;
        check_output("start_with_done_ignored", 64'(busy), 64'd0);

        $display("[TB] address wrap, write only, LFSR pattern");
        clear_logs();
        apply_stimulus(1'b1, 2'd0, 100);
        check_output("wrap_pass", 64'(pass_b), 64'd1);
        check_output("wrap_wr_count", 64'(wr_addr_b_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("wrap_addr%0d", i), 64'(wr_addr_b_q[i]), 64'(wrap_addrs[i]));
            check_output($sformatf("wrap_data%0d", i), wr_data_b_q[i], lfsr_words[i]);
        end

        $display("[TB] LFSR write then verify");
        clear_logs();
        apply_stimulus(1'b1, 2'd2, 100);
        check_output("lfsr_pass", 64'(pass_b), 64'd1);
        check_output("lfsr_err_count", 64'(err_count_b), 64'd0);
        check_output("lfsr_timeout", 64'(tg_timeout_b), 64'd0);
        check_output("lfsr_busy", 64'(busy_b), 64'd0);
        check_output("lfsr_first_err", 64'(first_err_addr_b) | first_err_data_b, 64'd0);
        check_output("lfsr_rd_count", 64'(rd_data_b_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("lfsr_rd_data%0d", i), rd_data_b_q[i], lfsr_words[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
